// File: rtl/vga_text_renderer.sv
// vga_text_renderer: text-mode pixel generator fed by the VGA timing encoder.
//
// Ports:
//   clk, rst_n                  pixel clock, synchronous active-low reset
//   x_i, y_i                    encoder pixel counters
//   visible_i, hsync_i, vsync_i encoder video enable and syncs (one cycle behind x_i/y_i)
//   ymax_i                      high throughout the last line of a frame
//   char_addr_o, char_en_o      char RAM read port (1-cycle latency)
//   char_data_i                 {bg IRGB, fg IRGB, code}
//   font_addr_o, font_data_i    font ROM read port {code, glyph row} -> 8 pixels, bit 7 leftmost
//   cursor_en_i, cursor_col_i, cursor_row_i  blinking underline cursor
//   rgb_o, hsync_o, vsync_o, de_o            pixel-aligned video out, five cycles after x_i/y_i
module vga_text_renderer #(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CHAR_ADDR_W  = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             x_i,
    input  logic [9:0]             y_i,
    input  logic                   visible_i,
    input  logic                   hsync_i,
    input  logic                   vsync_i,
    input  logic                   ymax_i,
    output logic [CHAR_ADDR_W-1:0] char_addr_o,
    output logic                   char_en_o,
    input  logic [15:0]            char_data_i,
    output logic [11:0]            font_addr_o,
    input  logic [7:0]             font_data_i,
    input  logic                   cursor_en_i,
    input  logic [6:0]             cursor_col_i,
    input  logic [4:0]             cursor_row_i,
    output logic [11:0]            rgb_o,
    output logic                   hsync_o,
    output logic                   vsync_o,
    output logic                   de_o
);

    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // Per-pixel side information that travels alongside the memory fetches.
    typedef struct packed {
        logic       hit;
        logic       area;
        logic [3:0] row;
        logic [2:0] xbit;
    } tag_t;

    logic                   in_area;
    logic [CHAR_ADDR_W-1:0] char_addr_d, char_addr_q;
    logic                   char_en_d, char_en_q;
    logic [11:0]            font_addr_d, font_addr_q;
    tag_t                   tag_d, t4;
    tag_t                   tag_q [4];
    logic [7:0]             attr_q [2];
    logic [3:0]             hs_q, vs_q, de_q;
    logic                   ymax_q, tick, wrap;
    logic [BW-1:0]          blink_cnt_d, blink_cnt_q;
    logic                   phase_d, phase_q;
    logic                   pix, cursor_on;
    logic [3:0]             nib;
    logic [11:0]            rgb_d, rgb_q;

    // Each channel bit c with intensity I expands to {c, I, c, I}: F, A, 5 or 0.
    function automatic logic [11:0] irgb(input logic [3:0] n);
        return {n[2], n[3], n[2], n[3], n[1], n[3], n[1], n[3], n[0], n[3], n[0], n[3]};
    endfunction

    always_comb begin
        in_area     = (x_i < 10'(COLS * 8)) && (y_i < 10'(ROWS * 16));
        char_en_d   = in_area;
        char_addr_d = in_area ? CHAR_ADDR_W'(y_i[8:4]) * CHAR_ADDR_W'(COLS) + CHAR_ADDR_W'(x_i[9:3]) : '0;
        // Cursor enable is folded into the hit flag so it is sampled with the coordinates.
        tag_d.hit   = cursor_en_i && (x_i[9:3] == cursor_col_i) && (y_i[8:4] == cursor_row_i);
        tag_d.area  = in_area;
        tag_d.row   = y_i[3:0];
        tag_d.xbit  = x_i[2:0];
        font_addr_d = {char_data_i[7:0], tag_q[1].row};
    end

    always_comb begin
        tick        = ymax_i && !ymax_q;
        wrap        = tick && (blink_cnt_q == BW'(BLINK_FRAMES - 1));
        blink_cnt_d = wrap ? '0 : tick ? blink_cnt_q + BW'(1) : blink_cnt_q;
        phase_d     = phase_q ^ wrap;
    end

    always_comb begin
        t4        = tag_q[3];
        pix       = font_data_i[~t4.xbit];
        cursor_on = t4.hit && phase_q && (t4.row[3:1] == 3'b111);
        nib       = (pix || cursor_on) ? attr_q[1][3:0] : attr_q[1][7:4];
        rgb_d     = t4.area ? irgb(nib) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            char_addr_q <= '0;
            char_en_q   <= 1'b0;
            font_addr_q <= '0;
            for (int i = 0; i < 4; i++) tag_q[i] <= '0;
            attr_q[0]   <= '0;
            attr_q[1]   <= '0;
            hs_q        <= '1;
            vs_q        <= '1;
            de_q        <= '0;
            ymax_q      <= 1'b0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            rgb_q       <= '0;
        end else begin
            char_addr_q <= char_addr_d;
            char_en_q   <= char_en_d;
            font_addr_q <= font_addr_d;
            tag_q[0]    <= tag_d;
            for (int i = 1; i < 4; i++) tag_q[i] <= tag_q[i-1];
            attr_q[0]   <= char_data_i[15:8];
            attr_q[1]   <= attr_q[0];
            // Syncs already lag x/y by one cycle, so four stages line them up with rgb.
            hs_q        <= {hs_q[2:0], hsync_i};
            vs_q        <= {vs_q[2:0], vsync_i};
            de_q        <= {de_q[2:0], visible_i};
            ymax_q      <= ymax_i;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            rgb_q       <= rgb_d;
        end
    end

    assign char_addr_o = char_addr_q;
    assign char_en_o   = char_en_q;
    assign font_addr_o = font_addr_q;
    assign rgb_o       = rgb_q;
    assign hsync_o     = hs_q[3];
    assign vsync_o     = vs_q[3];
    assign de_o        = de_q[3];

endmodule

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: directed pixels with a cycle-stamped scoreboard for vga_text_renderer.
module tb_vga_text_renderer;

    localparam int K_RGB = 0, K_ADDR = 1, K_EN = 2, K_FONT = 3, K_DE = 4, K_HS = 5, K_VS = 6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  x_i = '0, y_i = '0;
    logic        visible_i = 1'b0, hsync_i = 1'b1, vsync_i = 1'b1, ymax_i = 1'b0;
    logic [11:0] char_addr_o;
    logic        char_en_o;
    logic [15:0] char_data_i = '0;
    logic [11:0] font_addr_o;
    logic [7:0]  font_data_i = '0;
    logic        cursor_en_i = 1'b0;
    logic [6:0]  cursor_col_i = '0;
    logic [4:0]  cursor_row_i = '0;
    logic [11:0] rgb_o;
    logic        hsync_o, vsync_o, de_o;

    always #5 clk = ~clk;

    vga_text_renderer dut (
        .clk(clk), .rst_n(rst_n), .x_i(x_i), .y_i(y_i),
        .visible_i(visible_i), .hsync_i(hsync_i), .vsync_i(vsync_i), .ymax_i(ymax_i),
        .char_addr_o(char_addr_o), .char_en_o(char_en_o), .char_data_i(char_data_i),
        .font_addr_o(font_addr_o), .font_data_i(font_data_i),
        .cursor_en_i(cursor_en_i), .cursor_col_i(cursor_col_i), .cursor_row_i(cursor_row_i),
        .rgb_o(rgb_o), .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o)
    );

    logic [15:0] char_mem [4096];
    logic [7:0]  font_mem [4096];

    always @(posedge clk) begin
        if (char_en_o) char_data_i <= char_mem[char_addr_o];
        font_data_i <= font_mem[font_addr_o];
    end

    typedef struct {
        int          due;
        int          kind;
        logic [11:0] exp;
    } exp_t;

    exp_t  sb [$];
    string kname [7] = '{"rgb_o", "char_addr_o", "char_en_o", "font_addr_o", "de_o", "hsync_o", "vsync_o"};
    int    total = 0, bad = 0, cyc = 0;
    bit    pv = 1'b0, ph = 1'b1, pvs = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] actual(input int k);
        case (k)
            K_RGB:   return rgb_o;
            K_ADDR:  return char_addr_o;
            K_EN:    return {11'd0, char_en_o};
            K_FONT:  return font_addr_o;
            K_DE:    return {11'd0, de_o};
            K_HS:    return {11'd0, hsync_o};
            default: return {11'd0, vsync_o};
        endcase
    endfunction

    always @(negedge clk) begin
        exp_t keep [$];
        keep = {};
        foreach (sb[i]) begin
            if (sb[i].due == cyc) begin
                total++;
                if (actual(sb[i].kind) !== sb[i].exp) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h exp=%h", kname[sb[i].kind], cyc, actual(sb[i].kind), sb[i].exp);
                end
            end else if (sb[i].due < cyc) begin
                total++;
                bad++;
                $display("FAIL %s missed due=%0d cyc=%0d", kname[sb[i].kind], sb[i].due, cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;
    end

    task automatic push(input int due, input int kind, input logic [11:0] exp);
        exp_t e;
        e.due  = due;
        e.kind = kind;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    // One pixel per call; expectations are stamped with the cycle they must appear.
    task automatic pix(input int x, input int y, input bit vis, input bit hs, input bit vs,
                       input logic [11:0] rgb, input bit kill = 1'b0, input bit rst = 1'b0);
        int n, a;
        bit ia;
        @(negedge clk);
        rst_n     = !rst;
        x_i       = 10'(x);
        y_i       = 10'(y);
        visible_i = pv;
        hsync_i   = ph;
        vsync_i   = pvs;
        pv        = vis;
        ph        = hs;
        pvs       = vs;
        n         = cyc;
        ia        = (x < 640) && (y < 480);
        a         = ia ? (y / 16) * 80 + x / 8 : 0;
        if (rst) begin
            push(n + 1, K_RGB, 12'h000);
            push(n + 1, K_DE, 12'h0);
            push(n + 1, K_HS, 12'h1);
            push(n + 1, K_VS, 12'h1);
            push(n + 1, K_EN, 12'h0);
            push(n + 1, K_ADDR, 12'h0);
            push(n + 1, K_FONT, 12'h0);
            push(n + 5, K_RGB, 12'h000);
        end else begin
            push(n + 1, K_EN, 12'(ia));
            push(n + 1, K_ADDR, 12'(a));
            if (kill) begin
                push(n + 5, K_RGB, 12'h000);
                push(n + 5, K_DE, 12'h0);
                push(n + 5, K_HS, 12'h1);
                push(n + 5, K_VS, 12'h1);
            end else begin
                push(n + 5, K_RGB, rgb);
                push(n + 5, K_DE, 12'(vis));
                push(n + 5, K_HS, 12'(hs));
                push(n + 5, K_VS, 12'(vs));
                if (ia) push(n + 3, K_FONT, {char_mem[a][7:0], 4'(y % 16)});
            end
        end
    endtask

    task automatic idle();
        pix(700, 500, 1'b0, 1'b1, 1'b1, 12'h000);
    endtask

    task automatic ticks(input int k);
        repeat (6) idle();
        repeat (k) begin
            ymax_i = 1'b1;
            idle();
            ymax_i = 1'b0;
            idle();
        end
        repeat (2) idle();
    endtask

    task automatic cur_row(input int y, input logic [11:0] c);
        for (int x = 40; x < 48; x++) pix(x, y, 1'b1, 1'b1, 1'b1, c);
        pix(48, y, 1'b1, 1'b1, 1'b1, 12'h000);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            char_mem[i] = '0;
            font_mem[i] = '0;
        end
        char_mem[0]     = 16'h1F41;
        font_mem[12'h410] = 8'h80;
        char_mem[2399]  = 16'h2C7E;
        font_mem[12'h7EF] = 8'h01;
        char_mem[165]   = 16'h0F20;
        char_mem[37]    = 16'h0F00;
        font_mem[12'h000] = 8'hFF;

        // reset held with arbitrary inputs
        repeat (3) pix(int'($urandom_range(799)), int'($urandom_range(524)), 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 1'b1);
        repeat (2) idle();

        // first cell: glyph row 0x80, fg F, bg 1
        pix(0, 0, 1'b1, 1'b1, 1'b1, 12'hFFF);
        for (int x = 1; x < 8; x++) pix(x, 0, 1'b1, 1'b1, 1'b1, 12'h00A);

        // last cell and just outside the text area
        pix(638, 479, 1'b1, 1'b1, 1'b1, 12'h0A0);
        pix(639, 479, 1'b1, 1'b1, 1'b1, 12'hF55);
        pix(640, 479, 1'b0, 1'b1, 1'b1, 12'h000);
        pix(0, 480, 1'b0, 1'b1, 1'b1, 12'h000);

        // end of a line with an hsync pulse, then the start of the next line
        for (int x = 630; x < 660; x++) pix(x, 1, x < 640, !(x >= 645 && x < 652), 1'b1, 12'h000);
        for (int x = 0; x < 16; x++) pix(x, 1, 1'b1, 1'b1, 1'b1, x < 8 ? 12'h00A : 12'h000);
        for (int x = 0; x < 6; x++) pix(x, 490, 1'b0, 1'b1, 1'b0, 12'h000);
        repeat (3) idle();

        // blinking cursor at column 5, row 2
        cursor_col_i = 7'd5;
        cursor_row_i = 5'd2;
        cursor_en_i  = 1'b1;
        cur_row(46, 12'h000);
        cur_row(47, 12'h000);
        ticks(29);
        cur_row(46, 12'h000);
        ticks(1);
        cur_row(45, 12'h000);
        cur_row(46, 12'hFFF);
        cur_row(47, 12'hFFF);
        cursor_en_i = 1'b0;
        cur_row(46, 12'h000);
        cursor_en_i = 1'b1;
        ticks(29);
        cur_row(47, 12'hFFF);
        ticks(1);
        cur_row(46, 12'h000);
        cur_row(47, 12'h000);
        cursor_en_i = 1'b0;
        repeat (3) idle();

        // one-cycle reset in the middle of a line
        pix(295, 0, 1'b1, 1'b1, 1'b1, 12'h000);
        for (int x = 296; x < 300; x++) pix(x, 0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b1);
        pix(300, 0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b1);
        for (int x = 301; x < 304; x++) pix(x, 0, 1'b1, 1'b1, 1'b1, 12'hFFF);
        pix(304, 0, 1'b1, 1'b1, 1'b1, 12'h000);

        repeat (4) idle();
        repeat (7) @(negedge clk);
        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL %s never checked due=%0d", kname[sb[i].kind], sb[i].due);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
